// File: rtl/j68_pkg.sv
// rtl/j68_pkg.sv - shared types and constants for the J68 microcode loader
//
// Purpose: loader state encoding, error codes and microcode RAM geometry.
// Ports:   none (package).
package j68_pkg;

  localparam int UCODE_DEPTH = 2048;
  localparam int UCODE_WIDTH = 20;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR_LO = 3'd1,
    ST_HDR_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_CSUM   = 3'd5,
    ST_DONE   = 3'd6,
    ST_ERROR  = 3'd7
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_COUNT = 2'd1;
  localparam logic [1:0] ERR_CSUM  = 2'd2;

  // States in which the loader takes bytes from the stream.
  function automatic logic takes_bytes(state_t s);
    return (s == ST_HDR_LO) || (s == ST_HDR_HI) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/j68_byte_assembler.sv
// rtl/j68_byte_assembler.sv - packs 3 stream bytes into a 20-bit word, sums all frame bytes
//
// Purpose: byte lane counter, 20-bit word assembly register and running 8-bit checksum.
// Ports:
//   clock, reset, clocken  - clocking; synchronous active-high reset
//   clear                  - restart checksum and byte lane at the start of a load
//   accept                 - a frame byte is taken this cycle
//   data_phase             - accepted bytes are word bytes (not header/checksum)
//   data                   - the stream byte
//   word_done              - third byte of a word taken this cycle
//   word                   - assembled word {b2[3:0], b1, b0}
//   sum_zero               - running sum plus the current byte is 0 mod 256
module j68_byte_assembler
  import j68_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clocken,
  input  logic                   clear,
  input  logic                   accept,
  input  logic                   data_phase,
  input  logic [7:0]             data,
  output logic                   word_done,
  output logic [UCODE_WIDTH-1:0] word,
  output logic                   sum_zero
);

  logic [1:0] byte_cnt;
  logic [7:0] sum;
  logic [7:0] sum_next;

  assign sum_next  = sum + data;
  assign sum_zero  = (sum_next == 8'h00);
  assign word_done = accept && data_phase && (byte_cnt == 2'd2);

  always_ff @(posedge clock) begin
    if (reset) begin
      byte_cnt <= 2'd0;
      sum      <= 8'h00;
      word     <= '0;
    end else if (clocken) begin
      if (clear) begin
        byte_cnt <= 2'd0;
        sum      <= 8'h00;
      end else if (accept) begin
        sum <= sum_next;
        if (data_phase) begin
          // Word stays frozen while the top is in WRITE, since no byte is taken there.
          case (byte_cnt)
            2'd0: begin
              word[7:0] <= data;
              byte_cnt  <= 2'd1;
            end
            2'd1: begin
              word[15:8] <= data;
              byte_cnt   <= 2'd2;
            end
            default: begin
              // b2[7:4] only contributes to the checksum.
              word[19:16] <= data[3:0];
              byte_cnt    <= 2'd0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/j68_ucode_loader.sv
// rtl/j68_ucode_loader.sv - boot-time microcode image streamer for the J68 ucode RAM
//
// Purpose: parses {count_lo, count_hi, N x 3 word bytes, checksum} from a byte stream,
//          writes words to RAM from address 0 and releases the CPU on a good image.
// Ports:
//   clock, reset, clocken  - clocking; synchronous active-high reset, global enable
//   start                  - begin a load from IDLE/DONE/ERROR
//   in_valid/in_data/in_ready - byte stream handshake
//   wr_en/wr_addr/wr_data  - RAM write port
//   cpu_hold               - J68 reset, low only in DONE
//   busy/done/error/err_code - status
module j68_ucode_loader
  import j68_pkg::*;
#(
  parameter int MAX_WORDS = UCODE_DEPTH,
  parameter int ADDR_W    = 11
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clocken,
  input  logic                   start,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  output logic                   wr_en,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic [UCODE_WIDTH-1:0] wr_data,
  output logic                   cpu_hold,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [1:0]             err_code
);

  // One bit wider than the address so N == MAX_WORDS terminates without wrapping.
  localparam int IDX_W = ADDR_W + 1;

  state_t state, next_state;

  logic             accept;
  logic             start_take;
  logic [7:0]       count_lo;
  logic [15:0]      hdr_n;
  logic             hdr_bad;
  logic [IDX_W-1:0] n_words;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_next;
  logic             word_done;
  logic             sum_zero;

  logic       in_ready_d, wr_en_d, cpu_hold_d, busy_d, done_d, error_d;
  logic [1:0] err_code_d;

  assign accept     = in_valid && in_ready && clocken;
  assign start_take = start && clocken &&
                      ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR));
  assign hdr_n      = {in_data, count_lo};
  assign hdr_bad    = (hdr_n == 16'd0) || (hdr_n > 16'(MAX_WORDS));
  assign idx_next   = idx + 1'b1;
  assign wr_addr    = idx[ADDR_W-1:0];

  j68_byte_assembler u_asm (
    .clock      (clock),
    .reset      (reset),
    .clocken    (clocken),
    .clear      (start_take),
    .accept     (accept),
    .data_phase (state == ST_DATA),
    .data       (in_data),
    .word_done  (word_done),
    .word       (wr_data),
    .sum_zero   (sum_zero)
  );

  // State register; outputs are registered decodes of the next state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      in_ready <= 1'b0;
      wr_en    <= 1'b0;
      cpu_hold <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      err_code <= ERR_NONE;
    end else if (clocken) begin
      state    <= next_state;
      in_ready <= in_ready_d;
      wr_en    <= wr_en_d;
      cpu_hold <= cpu_hold_d;
      busy     <= busy_d;
      done     <= done_d;
      error    <= error_d;
      err_code <= err_code_d;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: if (start_take) next_state = ST_HDR_LO;
      ST_HDR_LO: if (accept) next_state = ST_HDR_HI;
      ST_HDR_HI: if (accept) next_state = hdr_bad ? ST_ERROR : ST_DATA;
      ST_DATA:   if (word_done) next_state = ST_WRITE;
      ST_WRITE:  next_state = (idx_next == n_words) ? ST_CSUM : ST_DATA;
      ST_CSUM:   if (accept) next_state = sum_zero ? ST_DONE : ST_ERROR;
      default:   next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready_d = takes_bytes(next_state);
    wr_en_d    = (next_state == ST_WRITE);
    cpu_hold_d = (next_state != ST_DONE);
    busy_d     = (next_state != ST_IDLE) && (next_state != ST_DONE) &&
                 (next_state != ST_ERROR);
    done_d     = (next_state == ST_DONE);
    error_d    = (next_state == ST_ERROR);
    err_code_d = err_code;
    if (start_take) begin
      err_code_d = ERR_NONE;
    end else if ((state == ST_HDR_HI) && accept && hdr_bad) begin
      err_code_d = ERR_COUNT;
    end else if ((state == ST_CSUM) && accept && !sum_zero) begin
      err_code_d = ERR_CSUM;
    end
  end

  // Header capture and word index.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_lo <= 8'h00;
      n_words  <= '0;
      idx      <= '0;
    end else if (clocken) begin
      if ((state == ST_HDR_LO) && accept) count_lo <= in_data;
      if ((state == ST_HDR_HI) && accept) begin
        n_words <= hdr_n[IDX_W-1:0];
        idx     <= '0;
      end
      if (state == ST_WRITE) idx <= idx_next;
    end
  end

endmodule

// File: tb/tb_j68_ucode_loader.sv
// tb/tb_j68_ucode_loader.sv - randomized frame-level bench for j68_ucode_loader
module tb_j68_ucode_loader;

  logic        clock = 1'b0;
  logic        reset, clocken, start, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, wr_en, cpu_hold, busy, done, error;
  logic [10:0] wr_addr;
  logic [19:0] wr_data;
  logic [1:0]  err_code;

  j68_ucode_loader dut (
    .clock    (clock),
    .reset    (reset),
    .clocken  (clocken),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .err_code (err_code)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;

  byte unsigned fb[$];
  int unsigned  wq[$];
  logic [10:0]  wa[$];
  logic [19:0]  wd[$];
  logic [10:0]  ea[$];
  logic [19:0]  ed[$];
  int           exp_nbytes;
  bit           exp_done;
  logic [1:0]   exp_code;

  // A RAM write happens at a rising edge where wr_en and clocken are both high.
  always @(negedge clock) begin
    if (wr_en && clocken && !reset) begin
      wa.push_back(wr_addr);
      wd.push_back(wr_data);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check_eq({tag, "_wr_en"},    32'(wr_en),    32'd0);
    check_eq({tag, "_wr_addr"},  32'(wr_addr),  32'd0);
    check_eq({tag, "_wr_data"},  32'(wr_data),  32'd0);
    check_eq({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
    check_eq({tag, "_busy"},     32'(busy),     32'd0);
    check_eq({tag, "_done"},     32'(done),     32'd0);
    check_eq({tag, "_error"},    32'(error),    32'd0);
    check_eq({tag, "_err_code"}, 32'(err_code), 32'd0);
  endtask

  // junk_mode: 0 -> b2[7:4]=0, 1 -> 0xF, 2 -> random. Checksum byte only when words follow.
  task automatic build_frame(input int n_hdr, input int n_words, input int junk_mode,
                             input int csum_delta);
    int unsigned w;
    logic [3:0]  junk;
    logic [7:0]  s;
    fb.delete();
    fb.push_back(8'(n_hdr));
    fb.push_back(8'(n_hdr >> 8));
    for (int i = 0; i < n_words; i++) begin
      w    = wq[i];
      junk = (junk_mode == 0) ? 4'h0 : (junk_mode == 1) ? 4'hF : 4'($urandom);
      fb.push_back(8'(w));
      fb.push_back(8'(w >> 8));
      fb.push_back({junk, 4'(w >> 16)});
    end
    if (n_words > 0) begin
      s = 8'h00;
      foreach (fb[i]) s = s + 8'(fb[i]);
      fb.push_back(8'(0 - int'(s) + csum_delta));
    end
  endtask

  // Reference: interpret the frame purely from the byte-level rules.
  task automatic model();
    int         n;
    logic [7:0] s;
    n = int'(fb[0]) + 256 * int'(fb[1]);
    ea.delete();
    ed.delete();
    if (n == 0 || n > 2048) begin
      exp_nbytes = 2;
      exp_done   = 1'b0;
      exp_code   = 2'd1;
    end else begin
      exp_nbytes = 3 + 3 * n;
      for (int i = 0; i < n; i++) begin
        ea.push_back(11'(i));
        ed.push_back({4'(fb[2 + 3 * i + 2]), 8'(fb[2 + 3 * i + 1]), 8'(fb[2 + 3 * i])});
      end
      s = 8'h00;
      for (int i = 0; i < exp_nbytes; i++) s = s + 8'(fb[i]);
      exp_done = (s == 8'h00);
      exp_code = exp_done ? 2'd0 : 2'd2;
    end
  endtask

  task automatic idle(input int n);
    clocken  = 1'b1;
    in_valid = 1'b0;
    start    = 1'b0;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_start();
    clocken = 1'b1;
    start   = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  // Offers fb[0..nb-1] with random gaps; a byte advances only when the DUT takes it.
  task automatic send_bytes(input int nb, input int en_pct, input int val_pct,
                            input int start_at, output bit timed_out);
    int i   = 0;
    int cyc = 0;
    bit acc;
    bit started = 1'b0;
    while (i < nb && cyc < 60000) begin
      clocken  = ($urandom_range(99) < en_pct);
      in_valid = ($urandom_range(99) < val_pct);
      in_data  = 8'(fb[i]);
      start    = (i == start_at) && !started;
      if (start) started = 1'b1;
      @(negedge clock);
      acc = in_valid && in_ready && clocken;
      @(posedge clock);
      #1;
      start = 1'b0;
      if (acc) i++;
      cyc++;
    end
    timed_out = (i < nb);
    clocken   = 1'b1;
    in_valid  = 1'b0;
  endtask

  task automatic run_frame(input string tag, input int en_pct, input int val_pct,
                           input int start_at);
    bit to;
    int mism;
    model();
    wa.delete();
    wd.delete();
    do_start();
    send_bytes(exp_nbytes, en_pct, val_pct, start_at, to);
    idle(3);
    check_eq({tag, "_timeout"}, 32'(to), 32'd0);
    check_eq({tag, "_nwrites"}, 32'(wa.size()), 32'(ea.size()));
    mism = 0;
    for (int i = 0; i < wa.size() && i < ea.size(); i++)
      if (wa[i] !== ea[i] || wd[i] !== ed[i]) mism++;
    check_eq({tag, "_write_mism"}, 32'(mism), 32'd0);
    check_eq({tag, "_done"},     32'(done),     32'(exp_done));
    check_eq({tag, "_error"},    32'(error),    32'(!exp_done));
    check_eq({tag, "_err_code"}, 32'(err_code), 32'(exp_code));
    check_eq({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(!exp_done));
    check_eq({tag, "_busy"},     32'(busy),     32'd0);
    check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd0);
  endtask

  initial begin
    bit to;
    int n;
    reset    = 1'b1;
    clocken  = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    check_reset_vals("por");
    reset = 1'b0;
    idle(2);
    check_eq("idle_cpu_hold", 32'(cpu_hold), 32'd1);
    check_eq("idle_in_ready", 32'(in_ready), 32'd0);

    // Two known words; start pulsed mid-DATA must be ignored.
    wq = '{32'h12345, 32'hABCDE};
    build_frame(2, 2, 0, 0);
    run_frame("n2", 100, 100, 4);
    if (wd.size() >= 2) begin
      check_eq("n2_w0", 32'(wd[0]), 32'h12345);
      check_eq("n2_w1", 32'(wd[1]), 32'hABCDE);
    end
    check_eq("n2_done_const", 32'(done), 32'd1);

    // Bad header counts.
    build_frame(0, 0, 0, 0);
    run_frame("n0", 100, 100, -1);
    build_frame(16'h0801, 0, 0, 0);
    run_frame("n801", 80, 80, -1);
    check_eq("n801_code_const", 32'(err_code), 32'd1);

    // Checksum off by one, upper nibble junk.
    wq = '{32'hC0458};
    build_frame(1, 1, 1, 1);
    run_frame("csum_bad", 100, 100, -1);
    if (wd.size() >= 1) check_eq("csum_bad_w0", 32'(wd[0]), 32'hC0458);
    check_eq("csum_bad_code_const", 32'(err_code), 32'd2);

    // Reset after 5 of 10 words, then a fresh full load.
    wq.delete();
    for (int i = 0; i < 10; i++) wq.push_back($urandom & 32'hFFFFF);
    build_frame(10, 10, 2, 0);
    wa.delete();
    wd.delete();
    do_start();
    send_bytes(2 + 15, 70, 70, -1, to);
    idle(3);
    check_eq("mid_timeout", 32'(to), 32'd0);
    check_eq("mid_nwrites", 32'(wa.size()), 32'd5);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check_reset_vals("mid_rst");
    reset = 1'b0;
    idle(1);
    run_frame("after_rst", 100, 90, -1);

    // Random short frames.
    for (int k = 0; k < 6; k++) begin
      n = $urandom_range(1, 6);
      wq.delete();
      for (int i = 0; i < n; i++) wq.push_back($urandom & 32'hFFFFF);
      build_frame(n, n, 2, ($urandom_range(1) == 0) ? 0 : $urandom_range(1, 255));
      run_frame($sformatf("rnd%0d", k), $urandom_range(60, 100), $urandom_range(50, 100),
                ($urandom_range(1) == 0) ? -1 : $urandom_range(2, 2 + 3 * n));
    end

    // Full depth with stalls and 50% clock enable.
    wq.delete();
    for (int i = 0; i < 2048; i++) wq.push_back($urandom & 32'hFFFFF);
    build_frame(2048, 2048, 2, 0);
    run_frame("n2048", 50, 70, -1);
    if (wa.size() > 0) check_eq("n2048_last_addr", 32'(wa[wa.size() - 1]), 32'h7FF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
